shift_by_variable_amount_pipelined: RTL

//   Pipelined barrel shifter for a variable shift amount: one stage per bit of the shift amount.

---
 rtl/shift_by_variable_amount_pipelined.sv | 94 +++++++++
 1 files changed

// File: rtl/shift_by_variable_amount_pipelined.sv
// Pipelined barrel shifter: stage k shifts by 2**k when amt[k] is set; one global stall enable.
// Optional rotate-right on op 11 is enabled by defining SHIFT_PIPE_ROTATE_EN.
module shift_by_variable_amount_pipelined #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [N-1:0]  up_data,
  input  logic [SW-1:0] up_amt,
  input  logic [1:0]    up_op,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [N-1:0]  down_data
);

  logic [N-1:0]  data_reg  [SW];
  logic [SW-1:0] amt_reg   [SW];
  logic [1:0]    op_reg    [SW];
  logic          valid_reg [SW];
  logic          sign_reg  [SW];
  logic          en;

  assign en         = !valid_reg[SW-1] || down_ready;
  assign up_ready   = en;
  assign down_valid = valid_reg[SW-1];
  assign down_data  = data_reg[SW-1];

  // The last stage's control fields have no consumer downstream.
  logic unused_tail;
  assign unused_tail = ^{amt_reg[SW-1], op_reg[SW-1], sign_reg[SW-1]};

  genvar gi;
  generate
    for (gi = 0; gi < SW; gi++) begin : g_stage
      localparam int D = 1 << gi;

      logic [N-1:0]  src_data;
      logic [SW-1:0] src_amt;
      logic [1:0]    src_op;
      logic          src_valid;
      logic          src_sign;
      logic [N-1:0]  data_next;

      if (gi == 0) begin : g_head
        // Bubbles load a zero payload so an undriven input never reaches the registers.
        assign src_valid = up_valid;
        assign src_data  = up_valid ? up_data : '0;
        assign src_amt   = up_valid ? up_amt : '0;
        assign src_op    = up_valid ? up_op : 2'b00;
        assign src_sign  = up_valid & up_data[N-1];
      end else begin : g_tail
        assign src_valid = valid_reg[gi-1];
        assign src_data  = data_reg[gi-1];
        assign src_amt   = amt_reg[gi-1];
        assign src_op    = op_reg[gi-1];
        assign src_sign  = sign_reg[gi-1];
      end

      always_comb begin
        data_next = src_data;
        if (src_amt[gi]) begin
          case (src_op)
            2'b00:   data_next = {src_data[N-1-D:0], {D{1'b0}}};
            2'b10:   data_next = {{D{src_sign}}, src_data[N-1:D]};
`ifdef SHIFT_PIPE_ROTATE_EN
            2'b11:   data_next = {src_data[D-1:0], src_data[N-1:D]};
`endif
            default: data_next = {{D{1'b0}}, src_data[N-1:D]};
          endcase
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_reg[gi]  <= '0;
          amt_reg[gi]   <= '0;
          op_reg[gi]    <= 2'b00;
          valid_reg[gi] <= 1'b0;
          sign_reg[gi]  <= 1'b0;
        end else if (en) begin
          data_reg[gi]  <= data_next;
          amt_reg[gi]   <= src_amt;
          op_reg[gi]    <= src_op;
          valid_reg[gi] <= src_valid;
          sign_reg[gi]  <= src_sign;
        end
      end
    end
  endgenerate

endmodule
